// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, fills the IF/ID register from a
// combinational instruction memory, and halts with a sticky fault on a bad PC.
module ifetch_ctrl #(
  parameter logic [63:0] MEM_SIZE = 64'd1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        fault,
  output logic [63:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pc_end;
  logic        bad_pc;

  assign imem_addr = pc;

  // The last byte of the word must lie inside memory; the sum wraps at 64 bits.
  assign pc_end = pc + 64'd3;
  assign bad_pc = (pc[1:0] != 2'b00) || (pc_end >= MEM_SIZE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 64'd0;
      fault       <= 1'b0;
      fault_addr  <= 64'd0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          if_valid <= 1'b0;
        end
        RUN: begin
          // A redirect wins even over a bad PC; a bad target faults one cycle later.
          if (br_taken) begin
            pc       <= br_target;
            if_valid <= 1'b0;
          end else if (bad_pc) begin
            state      <= HALT;
            fault      <= 1'b1;
            fault_addr <= pc;
            if_valid   <= 1'b0;
          end else if (!stall) begin
            if_instr <= imem_instr;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 64'd4;
            if (fetch_count != 32'hFFFF_FFFF) begin
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        HALT: begin
          if_valid <= 1'b0;
        end
        default: begin
          state    <= BOOT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: straight-line fetch, stall, redirect,
// bounds and misalignment faults, and reset recovery out of HALT.
module tb_ifetch_ctrl;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        fault;
  logic [63:0] fault_addr;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  ifetch_ctrl #(
    .MEM_SIZE(64'd1024),
    .RESET_PC(64'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed pattern of the word index so each word is distinct.
  function automatic logic [31:0] memWord(input logic [63:0] addr);
    return {8'hA5, 14'd0, addr[11:2]};
  endfunction

  assign imem_instr = memWord(imem_addr);

  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [63:0] target);
    reset     = r;
    stall     = s;
    br_taken  = b;
    br_target = target;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, {63'd0, if_valid}, 64'd0);
    checkOutput({tag, "_instr"}, {32'd0, if_instr}, 64'd0);
    checkOutput({tag, "_pc"}, if_pc, 64'd0);
    checkOutput({tag, "_fault"}, {63'd0, fault}, 64'd0);
    checkOutput({tag, "_faddr"}, fault_addr, 64'd0);
    checkOutput({tag, "_count"}, {32'd0, fetch_count}, 64'd0);
    checkOutput({tag, "_imem"}, imem_addr, 64'd0);
  endtask

  task automatic checkFetch(input string tag, input logic [63:0] pc,
                            input logic [31:0] count);
    checkOutput({tag, "_valid"}, {63'd0, if_valid}, 64'd1);
    checkOutput({tag, "_pc"}, if_pc, pc);
    checkOutput({tag, "_instr"}, {32'd0, if_instr}, {32'd0, memWord(pc)});
    checkOutput({tag, "_count"}, {32'd0, fetch_count}, {32'd0, count});
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
    step();
    checkResetValues("reset0");

    // Straight-line fetch: BOOT edge, then four fetches.
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    checkOutput("boot_valid", {63'd0, if_valid}, 64'd0);
    checkOutput("boot_imem", imem_addr, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkFetch($sformatf("line%0d", i), 64'(4 * i), 32'(i + 1));
    end

    // Restart and stall while if_pc=8.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
    step();
    checkResetValues("reset1");
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
    end
    checkFetch("prestall", 64'd8, 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkFetch($sformatf("stall%0d", i), 64'd8, 32'd3);
      checkOutput($sformatf("stall%0d_imem", i), imem_addr, 64'd12);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    checkFetch("release", 64'd12, 32'd4);

    // Redirect with simultaneous stall.
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h40);
    step();
    checkOutput("redir_valid", {63'd0, if_valid}, 64'd0);
    checkOutput("redir_imem", imem_addr, 64'h40);
    checkOutput("redir_pc_held", if_pc, 64'd12);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    checkFetch("redir_fetch", 64'h40, 32'd5);

    // Last in-bounds word, then out of bounds.
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h3FC);
    step();
    checkOutput("edge_redir_valid", {63'd0, if_valid}, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    checkFetch("edge_fetch", 64'h3FC, 32'd6);
    checkOutput("edge_imem", imem_addr, 64'h400);
    step();
    checkOutput("oob_fault", {63'd0, fault}, 64'd1);
    checkOutput("oob_faddr", fault_addr, 64'h400);
    checkOutput("oob_valid", {63'd0, if_valid}, 64'd0);

    // HALT must ignore redirects and stalls.
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h40);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h80);
    step();
    checkOutput("halt_fault", {63'd0, fault}, 64'd1);
    checkOutput("halt_faddr", fault_addr, 64'h400);
    checkOutput("halt_imem", imem_addr, 64'h400);
    checkOutput("halt_valid", {63'd0, if_valid}, 64'd0);
    checkOutput("halt_pc", if_pc, 64'h3FC);
    checkOutput("halt_instr", {32'd0, if_instr}, {32'd0, memWord(64'h3FC)});
    checkOutput("halt_count", {32'd0, fetch_count}, 64'd6);

    // Reset out of HALT, then a misaligned redirect.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h80);
    step();
    checkResetValues("reset2");
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    step();
    checkFetch("recover0", 64'd0, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h12);
    step();
    checkOutput("mis_redir_valid", {63'd0, if_valid}, 64'd0);
    checkOutput("mis_redir_fault", {63'd0, fault}, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    checkOutput("mis_fault", {63'd0, fault}, 64'd1);
    checkOutput("mis_faddr", fault_addr, 64'h12);
    checkOutput("mis_valid", {63'd0, if_valid}, 64'd0);

    // One-cycle reset, then the first fetch two edges later.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
    step();
    checkResetValues("reset3");
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    checkOutput("recover_boot_valid", {63'd0, if_valid}, 64'd0);
    step();
    checkFetch("recover1", 64'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
